// File: rtl/spi_alu_master_gen.sv
// SPI mode-0 master for the SPI ALU link: shifts out opcode, op_a, op_b
// and reads back a DATA_W+1-bit result behind a start/busy/done handshake.
module spi_alu_master_gen #(
  parameter int DATA_W    = 8,
  parameter int OP_W      = 3,
  parameter int CLK_DIV   = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [OP_W-1:0]   opcode,
  input  logic [DATA_W-1:0] op_a,
  input  logic [DATA_W-1:0] op_b,
  output logic              busy,
  output logic              done,
  output logic [DATA_W:0]   result,
  output logic              sclk,
  output logic              cs_n,
  output logic              mosi,
  input  logic              miso
);
  localparam int NTX = OP_W + 2 * DATA_W;
  localparam int NRX = DATA_W + 1;
  localparam int NB  = NTX + NRX;
  localparam int DW  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BW  = $clog2(NB + 1);
  localparam logic [DW-1:0] DIV_MAX = DW'(CLK_DIV - 1);
  localparam logic [BW-1:0] TX_LAST = BW'(NTX - 1);
  localparam logic [BW-1:0] RX_LAST = BW'(NB - 1);

  typedef enum logic [2:0] {
    IDLE, SETUP, TX, RX, GUARD, DONE
  } state_t;

  state_t          state, state_d;
  logic [DW-1:0]   div, div_d;
  logic [BW-1:0]   bitc, bitc_d;
  logic [NTX-1:0]  tx_sr, tx_sr_d;
  logic [NRX-1:0]  rx_sr, rx_sr_d;
  logic [NRX-1:0]  result_d;
  logic            busy_d, done_d;
  logic            sclk_d, cs_n_d, mosi_d;
  logic [OP_W-1:0]   op_ord;
  logic [DATA_W-1:0] a_ord, b_ord;
  logic            half_end;

  // Fields are pre-reversed for LSB-first so the shifter always sends its MSB.
  always_comb begin
    for (int i = 0; i < OP_W; i++)
      op_ord[i] = MSB_FIRST ? opcode[i] : opcode[OP_W-1-i];
    for (int i = 0; i < DATA_W; i++) begin
      a_ord[i] = MSB_FIRST ? op_a[i] : op_a[DATA_W-1-i];
      b_ord[i] = MSB_FIRST ? op_b[i] : op_b[DATA_W-1-i];
    end
  end

  assign half_end = (div == DIV_MAX);

  always_comb begin
    state_d  = state;
    div_d    = div;
    bitc_d   = bitc;
    tx_sr_d  = tx_sr;
    rx_sr_d  = rx_sr;
    result_d = result;
    busy_d   = busy;
    done_d   = 1'b0;
    sclk_d   = sclk;
    cs_n_d   = cs_n;
    mosi_d   = mosi;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_d = SETUP;
          tx_sr_d = {op_ord, a_ord, b_ord};
          rx_sr_d = '0;
          div_d   = '0;
          bitc_d  = '0;
          busy_d  = 1'b1;
          cs_n_d  = 1'b0;
          mosi_d  = op_ord[OP_W-1];
        end
      end
      SETUP: begin
        div_d = div + 1'b1;
        if (half_end) begin
          div_d   = '0;
          state_d = TX;
        end
      end
      TX, RX: begin
        div_d = div + 1'b1;
        if (half_end) begin
          div_d  = '0;
          sclk_d = ~sclk;
          if (!sclk) begin
            if (state == RX)
              rx_sr_d = MSB_FIRST ? {rx_sr[NRX-2:0], miso}
                                  : {miso, rx_sr[NRX-1:1]};
          end else begin
            bitc_d = bitc + 1'b1;
            if (state == TX) begin
              tx_sr_d = {tx_sr[NTX-2:0], 1'b0};
              mosi_d  = tx_sr[NTX-2];
              if (bitc == TX_LAST) begin
                mosi_d  = 1'b0;
                state_d = RX;
              end
            end else if (bitc == RX_LAST) begin
              state_d = GUARD;
              cs_n_d  = 1'b1;
            end
          end
        end
      end
      GUARD: begin
        div_d = div + 1'b1;
        if (half_end) begin
          div_d    = '0;
          state_d  = DONE;
          done_d   = 1'b1;
          result_d = rx_sr;
        end
      end
      DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        bitc_d  = '0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      div    <= '0;
      bitc   <= '0;
      tx_sr  <= '0;
      rx_sr  <= '0;
      result <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      sclk   <= 1'b0;
      cs_n   <= 1'b1;
      mosi   <= 1'b0;
    end else begin
      state  <= state_d;
      div    <= div_d;
      bitc   <= bitc_d;
      tx_sr  <= tx_sr_d;
      rx_sr  <= rx_sr_d;
      result <= result_d;
      busy   <= busy_d;
      done   <= done_d;
      sclk   <= sclk_d;
      cs_n   <= cs_n_d;
      mosi   <= mosi_d;
    end
  end

endmodule

// File: tb/tb_spi_alu_master_gen.sv
// Bench for spi_alu_master_gen: three configurations, each with an ALU
// slave, a cycle-level frame model and directed plus random frames.
module tb_spi_alu_master_gen;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    int o;
    int a;
    int b;
    int r;
    int f6;
  } vec_t;

  task automatic check(input string nm, input logic [31:0] got,
                       input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, got, want);
    end
  endtask

  for (genvar g = 0; g < 3; g++) begin : g_cfg
    localparam int DW  = (g == 1) ? 3 : 8;
    localparam int OW  = 3;
    localparam int CD  = (g == 0) ? 4 : (g == 1) ? 2 : 1;
    localparam bit MF  = (g != 2);
    localparam int NTX = OW + 2 * DW;
    localparam int NRX = DW + 1;
    localparam int NB  = NTX + NRX;
    localparam int LAT = CD * (2 + 2 * NB);
    localparam int LAT_HAND = (g == 0) ? 232 : (g == 1) ? 56 : 58;
    localparam int NB_HAND  = (g == 1) ? 13 : 28;

    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          miso = 1'b0;
    logic [OW-1:0] opcode = '0;
    logic [DW-1:0] op_a = '0;
    logic [DW-1:0] op_b = '0;
    logic          busy, done, sclk, cs_n, mosi;
    logic [DW:0]   result;
    bit            chk_on = 1'b0;
    bit            fin = 1'b0;

    spi_alu_master_gen #(
      .DATA_W(DW), .OP_W(OW), .CLK_DIV(CD), .MSB_FIRST(MF)
    ) dut (
      .clk(clk), .rst(rst), .start(start), .opcode(opcode),
      .op_a(op_a), .op_b(op_b), .busy(busy), .done(done),
      .result(result), .sclk(sclk), .cs_n(cs_n), .mosi(mosi),
      .miso(miso)
    );

    function automatic logic [DW:0] alu(input logic [OW-1:0] op,
                                        input logic [DW-1:0] a,
                                        input logic [DW-1:0] b);
      case (op)
        OW'(0):  return {1'b0, a} + {1'b0, b};
        OW'(1):  return {1'b0, a} - {1'b0, b};
        OW'(2):  return {1'b0, ~a};
        default: return {1'b0, a};
      endcase
    endfunction

    // Frame model: k counts cycles since the accept edge.
    bit            act = 1'b0;
    int            k = 0;
    logic [OW-1:0] mo = '0;
    logic [DW-1:0] ma = '0;
    logic [DW-1:0] mb = '0;
    logic [DW:0]   mres = '0;

    function automatic logic txbit(input int j);
      int i;
      int len;
      logic [31:0] v;
      if (j < OW) begin
        i = j; len = OW; v = 32'(mo);
      end else if (j < OW + DW) begin
        i = j - OW; len = DW; v = 32'(ma);
      end else begin
        i = j - OW - DW; len = DW; v = 32'(mb);
      end
      return MF ? v[len-1-i] : v[i];
    endfunction

    always @(posedge clk or posedge rst) begin
      if (rst) begin
        act = 1'b0;
        k = 0;
        mres = '0;
      end else if (!act) begin
        if (start) begin
          act = 1'b1;
          k = 0;
          mo = opcode;
          ma = op_a;
          mb = op_b;
        end
      end else begin
        k++;
        if (k == LAT) mres = alu(mo, ma, mb);
        if (k > LAT) act = 1'b0;
      end
    end

    always @(negedge clk) begin
      int   j;
      bit   in_bits;
      logic e_sclk;
      logic e_mosi;
      if (chk_on) begin
        in_bits = act && k >= CD && k < CD + 2 * CD * NB;
        e_sclk  = in_bits && (((k - CD) / CD) % 2 == 1);
        j = (k < CD) ? 0 : (k - CD) / (2 * CD);
        e_mosi = 1'b0;
        if (act && j < NTX) e_mosi = txbit(j);
        check($sformatf("g%0d busy k=%0d", g, k), 32'(busy), 32'(act));
        check($sformatf("g%0d done k=%0d", g, k), 32'(done),
              32'(act && k == LAT));
        check($sformatf("g%0d cs_n k=%0d", g, k), 32'(cs_n),
              32'(!(act && k < CD + 2 * CD * NB)));
        check($sformatf("g%0d sclk k=%0d", g, k), 32'(sclk), 32'(e_sclk));
        check($sformatf("g%0d mosi k=%0d", g, k), 32'(mosi), 32'(e_mosi));
        check($sformatf("g%0d result k=%0d", g, k), 32'(result), 32'(mres));
      end
    end

    // ALU slave: decodes MOSI fields, answers on MISO in mode 0.
    bit          sq[$];
    bit          last_q[$];
    int          scnt = 0;
    logic [DW:0] srsp = '0;
    int          rises = 0;

    function automatic int unsigned fld(input int o, input int len);
      int unsigned v = 0;
      for (int i = 0; i < len; i++)
        if (sq[o+i]) v |= MF ? (32'd1 << (len - 1 - i)) : (32'd1 << i);
      return v;
    endfunction

    always @(posedge sclk) rises++;

    always @(posedge sclk or negedge sclk or posedge cs_n or posedge rst) begin
      int unsigned so, sa, sb;
      if (rst || cs_n) begin
        scnt = 0;
        sq.delete();
        miso = 1'b0;
      end else if (sclk) begin
        if (scnt < NTX) sq.push_back(mosi);
        scnt++;
        if (scnt == NTX) begin
          so = fld(0, OW);
          sa = fld(OW, DW);
          sb = fld(OW + DW, DW);
          check($sformatf("g%0d slave opcode", g), so, 32'(mo));
          check($sformatf("g%0d slave op_a", g), sa, 32'(ma));
          check($sformatf("g%0d slave op_b", g), sb, 32'(mb));
          srsp = alu(OW'(so), DW'(sa), DW'(sb));
          last_q = sq;
        end
      end else if (scnt >= NTX && scnt < NB) begin
        miso = MF ? srsp[NRX-1-(scnt-NTX)] : srsp[scnt-NTX];
      end
    end

    int hi_run = 0;
    int last_gap = 0;
    always @(negedge clk) begin
      if (cs_n === 1'b1) begin
        hi_run++;
      end else begin
        if (hi_run > 0) last_gap = hi_run;
        hi_run = 0;
      end
    end

    task automatic wait_done(input bit drop, input bit poke, output int lat);
      lat = -1;
      for (int c = 0; c < LAT + 64 && lat < 0; c++) begin
        @(negedge clk);
        if (drop) start = 1'b0;
        if (poke && c == LAT / 2) begin
          start  = 1'b1;
          opcode = OW'($urandom);
          op_a   = DW'($urandom);
          op_b   = DW'($urandom);
        end
        if (done === 1'b1) lat = c;
      end
      check($sformatf("g%0d done seen", g), 32'(lat >= 0), 32'd1);
    endtask

    task automatic run(input logic [OW-1:0] o, input logic [DW-1:0] a,
                       input logic [DW-1:0] b, input bit poke,
                       output int lat, output int nr);
      int r0;
      @(negedge clk);
      start = 1'b1;
      opcode = o;
      op_a = a;
      op_b = b;
      r0 = rises;
      @(posedge clk);
      wait_done(1'b1, poke, lat);
      nr = rises - r0;
    endtask

    initial begin
      vec_t          dv[$];
      int            lat, nr, r0;
      logic [5:0]    f;
      logic [OW-1:0] ro, ho;
      logic [DW-1:0] ra, rb, ha, hb;
      string         p;
      p = $sformatf("g%0d", g);
      case (g)
        0: dv.push_back('{0, 'hFF, 'h01, 'h100, 'b000111});
        1: begin
          dv.push_back('{0, 7, 2, 'b1001, 'b000111});
          dv.push_back('{1, 7, 6, 'b0001, 'b001111});
          dv.push_back('{2, 7, 0, 'b0000, 'b010111});
        end
        default: dv.push_back('{1, 'h0A, 'h03, 'h007, 'b100010});
      endcase

      repeat (3) @(negedge clk);
      chk_on = 1'b1;
      check({p, " rst cs_n"}, 32'(cs_n), 32'd1);
      check({p, " rst sclk"}, 32'(sclk), 32'd0);
      check({p, " rst mosi"}, 32'(mosi), 32'd0);
      check({p, " rst busy"}, 32'(busy), 32'd0);
      check({p, " rst done"}, 32'(done), 32'd0);
      check({p, " rst result"}, 32'(result), 32'd0);
      rst = 1'b0;
      r0 = rises;
      repeat (100) @(negedge clk);
      check({p, " idle sclk edges"}, 32'(rises - r0), 32'd0);

      foreach (dv[i]) begin
        run(OW'(dv[i].o), DW'(dv[i].a), DW'(dv[i].b), 1'b0, lat, nr);
        check($sformatf("%s dir%0d result", p, i), 32'(result), dv[i].r);
        check($sformatf("%s dir%0d latency", p, i), lat, LAT_HAND);
        check($sformatf("%s dir%0d sclk rises", p, i), nr, NB_HAND);
        for (int b = 0; b < 6; b++) f[5-b] = last_q[b];
        check($sformatf("%s dir%0d first bits", p, i), 32'(f), dv[i].f6);
      end

      for (int i = 0; i < 8; i++) begin
        ro = OW'($urandom_range(0, 7));
        ra = DW'($urandom);
        rb = DW'($urandom);
        run(ro, ra, rb, i[0], lat, nr);
        check($sformatf("%s rnd%0d result", p, i), 32'(result),
              32'(alu(ro, ra, rb)));
        check($sformatf("%s rnd%0d latency", p, i), lat, LAT_HAND);
      end

      @(negedge clk);
      start = 1'b1;
      opcode = OW'(0);
      op_a = DW'($urandom);
      op_b = DW'($urandom);
      ho = opcode;
      ha = op_a;
      hb = op_b;
      @(posedge clk);
      wait_done(1'b0, 1'b0, lat);
      check({p, " hold first latency"}, lat, LAT_HAND);
      for (int c = 0; c < 16 && cs_n === 1'b1; c++) @(negedge clk);
      #1;
      check({p, " hold restart"}, 32'(cs_n), 32'd0);
      check({p, " hold guard gap"}, 32'(last_gap >= CD + 1), 32'd1);
      repeat (5) @(negedge clk);
      opcode = ~ho;
      op_a = ~ha;
      op_b = ~hb;
      repeat (5) @(negedge clk);
      start = 1'b0;
      wait_done(1'b1, 1'b0, lat);
      check({p, " hold second result"}, 32'(result), 32'(alu(ho, ha, hb)));

      @(negedge clk);
      start = 1'b1;
      opcode = OW'($urandom);
      op_a = DW'($urandom);
      op_b = DW'($urandom);
      r0 = rises;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      for (int c = 0; c < LAT + 64 && rises - r0 < NTX + 4; c++)
        @(negedge clk);
      check({p, " reached rx bit3"}, 32'(rises - r0), 32'(NTX + 4));
      #2 rst = 1'b1;
      #1;
      check({p, " midrst cs_n"}, 32'(cs_n), 32'd1);
      check({p, " midrst sclk"}, 32'(sclk), 32'd0);
      check({p, " midrst busy"}, 32'(busy), 32'd0);
      check({p, " midrst done"}, 32'(done), 32'd0);
      check({p, " midrst result"}, 32'(result), 32'd0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      ro = OW'($urandom_range(0, 2));
      ra = DW'($urandom);
      rb = DW'($urandom);
      run(ro, ra, rb, 1'b0, lat, nr);
      check({p, " post-rst result"}, 32'(result), 32'(alu(ro, ra, rb)));
      check({p, " post-rst latency"}, lat, LAT_HAND);
      check({p, " post-rst sclk rises"}, nr, NB_HAND);
      repeat (4) @(negedge clk);
      fin = 1'b1;
    end
  end

  initial begin
    int cyc;
    cyc = 0;
    while (!(g_cfg[0].fin && g_cfg[1].fin && g_cfg[2].fin) && cyc < 50000) begin
      @(negedge clk);
      cyc++;
    end
    check("all configs finished",
          32'(g_cfg[0].fin && g_cfg[1].fin && g_cfg[2].fin), 32'd1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/spi_alu_master_gen.md
Name: spi_alu_master_gen

Overview:
Parametrised next-generation SPI master for the SPI ALU link. One frame carries an opcode plus two operands of DATA_W bits on MOSI, then reads a DATA_W+1-bit result, including carry/borrow, back on MISO. A start/busy/done handshake fronts the block, so a controller or bench launches transactions without bit-banging. SPI mode 0, single slave; sits between system logic and the spi_if pins.

Parameters:
DATA_W, 8, operand width in bits (>=1); result width is DATA_W+1.
OP_W, 3, opcode width in bits (>=1); ADD=0, SUB=1, INV=2, others passed through unchanged.
CLK_DIV, 4, clk cycles per SCLK half-period (>=1).
MSB_FIRST, 1, 1: each field shifted MSB first; 0: LSB first (TX and RX alike).

Ports:
clk  in  1  system clock, all logic on rising edge.
rst  in  1  asynchronous active-high reset.
start  in  1  request; accepted only in IDLE.
opcode  in  OP_W  operation code, captured on accept.
op_a  in  DATA_W  operand A, captured on accept.
op_b  in  DATA_W  operand B, captured on accept.
busy  out  1  high from the accept edge through the done cycle.
done  out  1  one-cycle pulse; result valid.
result  out  DATA_W+1  last received result, held until the next done.
sclk  out  1  SPI clock, idle low.
cs_n  out  1  chip select, active low.
mosi  out  1  serial data to slave.
miso  in  1  serial data from slave.

Behaviour:
- Reset, async and immediate, including mid-frame: state=IDLE, busy=0, done=0, result=0, sclk=0, cs_n=1, mosi=0, shift registers and counters 0.
- NTX=OP_W+2*DATA_W, NRX=DATA_W+1, NB=NTX+NRX.
- TX frame order: opcode, then op_a, then op_b. Bit order within each field per MSB_FIRST.
- States: IDLE -> SETUP -> TX -> RX -> GUARD -> DONE -> IDLE.
- IDLE, start=1 at edge E0: capture inputs; busy=1, cs_n=0, mosi=first TX bit, all from E0.
- start while busy is ignored; inputs changing during a frame have no effect.
- SETUP: CLK_DIV cycles with sclk=0.
- Bit period = 2*CLK_DIV cycles: sclk low for CLK_DIV cycles, then high for CLK_DIV cycles.
- mosi changes only on the clk edge that drives sclk 1->0; it is stable through each rising SCLK edge.
- TX: NTX bit periods. On the final TX falling edge, mosi is driven 0 and held 0 through RX.
- RX: NRX bit periods. miso is sampled on the clk edge that drives sclk 0->1, assembled per MSB_FIRST.
- GUARD: sclk=0 and cs_n=1 for CLK_DIV cycles.
- DONE: one cycle with done=1 and busy=1; result is updated on the same edge done rises. Next edge: busy=0, done=0, IDLE.
- Timing: done=1 in the cycle starting CLK_DIV*(2+2*NB) edges after E0. Defaults: NB=28, so 232 cycles.
- start=1 in the cycle after done falls is accepted, giving back-to-back frames with a guard gap of at least CLK_DIV+1 cycles of cs_n=1.
- Counters: the half-period counter wraps at CLK_DIV-1; the bit counter sizes to clog2(NB+1). There is no overflow at maximum widths.
- result is never partially updated: the RX shift register copies to result only in DONE. A reset before DONE leaves result=0.

Test Plan:
- Reset idle: rst pulse, no start -> cs_n=1, sclk=0, mosi=0, busy=0, done=0, result=0; no sclk edges for 100 cycles.
- ADD frame, defaults: opcode=0, a=8'hFF, b=8'h01, slave model returns a+b -> 19 MOSI bits decode to 3'b000,8'hFF,8'h01; result=9'h100; done exactly 232 cycles after the accept edge; exactly 28 sclk rising edges.
- Legacy widths (DATA_W=3, CLK_DIV=2): ADD 7,2 -> 4'b1001; SUB 7,6 -> 4'b0001; INV 7 -> 4'b0000. Each frame is 9 TX + 4 RX bits, and done arrives 2*(2+26)=56 cycles after accept.
- LSB-first (MSB_FIRST=0, DATA_W=8): opcode=1, a=8'h0A, b=8'h03 -> MOSI first bits are 1,0,0 then 0,1,0,1...; a slave returning 9'h007 LSB first gives result=9'h007.
- Busy handling: start held high throughout -> second frame begins only after done falls, and a guard of at least CLK_DIV+1 cycles with cs_n=1 is seen. A start pulse mid-frame with different operands does not change the MOSI bit stream.
- Reset mid-frame: assert rst during RX bit 3 -> same cycle cs_n=1, sclk=0, busy=0; result stays 0; next start produces a full, correct frame.
